// File: rtl/sevenseg_fe_multi.sv
// Seven-segment front-end: formats a packed binary value as hex or decimal nibbles,
// as one field or FIELDS split fields, sharing one serial shift-add-3 BCD converter.
module sevenseg_fe_multi #(
  parameter int DIGITS = 8,
  parameter int FIELDS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] input_value,
  input  logic                cfg_split,
  input  logic [FIELDS-1:0]   cfg_dec,
  input  logic                cfg_lzb,
  input  logic                freeze,
  output logic [4*DIGITS-1:0] display,
  output logic [DIGITS-1:0]   digit_enable,
  output logic [FIELDS-1:0]   field_ovf,
  output logic                frame_done
);
  localparam int FD   = DIGITS / FIELDS;
  localparam int WMAX = 4 * DIGITS;
  // ceil(W/3)+1 BCD digits always hold a W-bit value since log10(2) < 1/3
  localparam int BD   = (WMAX + 2) / 3 + 1;
  localparam int BW   = 4 * BD;
  localparam int FIW  = (FIELDS > 1) ? $clog2(FIELDS) : 1;
  localparam int CW   = $clog2(WMAX + 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_STORE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FIW-1:0]    fidx_q, fidx_d;
  logic              split_q, split_d;
  logic              lzb_q, lzb_d;
  logic [FIELDS-1:0] dec_q, dec_d;
  logic [WMAX-1:0]   bin_q, bin_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WMAX-1:0]   disp_q, disp_d;
  logic [DIGITS-1:0] den_q, den_d;
  logic [FIELDS-1:0] ovf_q, ovf_d;
  logic              done_q, done_d;

  logic              use_live_s;
  logic              geo_split_s;
  logic [FIELDS-1:0] geo_dec_vec_s;
  logic [FIW-1:0]    dec_idx_s;
  logic              geo_dec_s;
  int                nd_s;
  logic [WMAX-1:0]   slice_s;
  logic              shift_in_s;
  logic [BW-1:0]     adj_s;
  logic              ovf_s;
  logic [WMAX-1:0]   fv_s;
  logic              run_s;
  logic [DIGITS-1:0] en_s;
  logic              last_s;

  // Field geometry, slice capture, BCD adjust and the formatted field value
  always_comb begin
    // Field 0 in LOAD samples live config; everything after uses the frame's latched copy
    use_live_s = (state_q == ST_LOAD) && (fidx_q == '0);
    if (use_live_s) begin
      geo_split_s   = cfg_split;
      geo_dec_vec_s = cfg_dec;
    end else begin
      geo_split_s   = split_q;
      geo_dec_vec_s = dec_q;
    end
    if (geo_split_s) begin
      dec_idx_s = fidx_q;
      nd_s      = FD;
    end else begin
      dec_idx_s = '0;
      nd_s      = DIGITS;
    end
    geo_dec_s = geo_dec_vec_s[dec_idx_s];

    slice_s = '0;
    for (int b = 0; b < WMAX; b++) begin
      if (!geo_split_s) begin
        slice_s[b] = input_value[b];
      end else if (b < 4 * FD) begin
        slice_s[b] = input_value[4 * FD * int'(fidx_q) + b];
      end else begin
        slice_s[b] = 1'b0;
      end
    end

    shift_in_s = geo_split_s ? bin_q[4*FD-1] : bin_q[WMAX-1];
    adj_s = '0;
    for (int i = 0; i < BD; i++) begin
      adj_s[4*i +: 4] = bcd_q[4*i +: 4] + ((bcd_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end

    ovf_s = 1'b0;
    for (int i = 0; i < BD; i++) begin
      ovf_s = ovf_s | (geo_dec_s && (i >= nd_s) && (bcd_q[4*i +: 4] != 4'd0));
    end

    fv_s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i >= nd_s) begin
        fv_s[4*i +: 4] = 4'd0;
      end else if (!geo_dec_s) begin
        fv_s[4*i +: 4] = bin_q[4*i +: 4];
      end else if (ovf_s) begin
        fv_s[4*i +: 4] = 4'd9;
      end else begin
        fv_s[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end

    // Scan from the top so run_s marks every digit at or below the highest nonzero one
    run_s = 1'b0;
    en_s  = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run_s   = run_s | (fv_s[4*i +: 4] != 4'd0);
      en_s[i] = (i < nd_s) && (!lzb_q || run_s || (i == 0));
    end

    last_s = !split_q || (fidx_q == FIW'(FIELDS - 1));
  end

  // Sequencer next-state and output update
  always_comb begin
    state_d = state_q;
    fidx_d  = fidx_q;
    split_d = split_q;
    lzb_d   = lzb_q;
    dec_d   = dec_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    den_d   = den_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (fidx_q == '0) begin
          split_d = cfg_split;
          dec_d   = cfg_dec;
          lzb_d   = cfg_lzb;
        end else begin
          split_d = split_q;
          dec_d   = dec_q;
          lzb_d   = lzb_q;
        end
        bin_d   = slice_s;
        bcd_d   = '0;
        cnt_d   = geo_split_s ? CW'(4 * FD) : CW'(WMAX);
        state_d = geo_dec_s ? ST_SHIFT : ST_STORE;
      end
      ST_SHIFT: begin
        bcd_d = (adj_s << 1) | BW'(shift_in_s);
        bin_d = bin_q << 1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_STORE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_STORE: begin
        if (freeze) begin
          disp_d = disp_q;
        end else if (!split_q) begin
          disp_d   = fv_s;
          den_d    = en_s;
          ovf_d    = '0;
          ovf_d[0] = ovf_s;
        end else begin
          for (int d = 0; d < DIGITS; d++) begin
            if ((d / FD) == int'(fidx_q)) begin
              disp_d[4*d +: 4] = fv_s[4*(d % FD) +: 4];
              den_d[d]         = en_s[d % FD];
            end else begin
              disp_d[4*d +: 4] = disp_q[4*d +: 4];
              den_d[d]         = den_q[d];
            end
          end
          for (int f = 0; f < FIELDS; f++) begin
            ovf_d[f] = (f == int'(fidx_q)) ? ovf_s : ovf_q[f];
          end
        end
        if (last_s) begin
          done_d = 1'b1;
          fidx_d = '0;
        end else begin
          fidx_d = fidx_q + FIW'(1);
        end
        state_d = ST_LOAD;
      end
      default: begin
        state_d = ST_LOAD;
        fidx_d  = '0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_LOAD;
      fidx_q  <= '0;
      split_q <= 1'b0;
      lzb_q   <= 1'b0;
      dec_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      den_q   <= '0;
      ovf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fidx_q  <= fidx_d;
      split_q <= split_d;
      lzb_q   <= lzb_d;
      dec_q   <= dec_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      den_q   <= den_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign display      = disp_q;
  assign digit_enable = den_q;
  assign field_ovf    = ovf_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_sevenseg_fe_multi.sv
// Directed self-checking bench for sevenseg_fe_multi (DIGITS=8, FIELDS=2).
module tb_sevenseg_fe_multi;
  localparam int DIGITS = 8;
  localparam int FIELDS = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [4*DIGITS-1:0] input_value;
  logic                cfg_split;
  logic [FIELDS-1:0]   cfg_dec;
  logic                cfg_lzb;
  logic                freeze;
  logic [4*DIGITS-1:0] display;
  logic [DIGITS-1:0]   digit_enable;
  logic [FIELDS-1:0]   field_ovf;
  logic                frame_done;

  int checks = 0;
  int errors = 0;

  sevenseg_fe_multi #(.DIGITS(DIGITS), .FIELDS(FIELDS)) dut (
    .clk(clk), .reset(reset), .input_value(input_value), .cfg_split(cfg_split),
    .cfg_dec(cfg_dec), .cfg_lzb(cfg_lzb), .freeze(freeze), .display(display),
    .digit_enable(digit_enable), .field_ovf(field_ovf), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Counts negedges until frame_done is seen high, bounded by budget
  task automatic wait_done(input int budget, output int n, output bit ok);
    ok = 1'b0;
    n  = 0;
    while (n < budget && !ok) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  // Waits two frame_done pulses so the last frame fully used the current settings
  task automatic settle(input string tag);
    int n;
    bit ok1, ok2;
    wait_done(200, n, ok1);
    wait_done(200, n, ok2);
    checks++;
    if (!(ok1 && ok2)) begin errors++; $display("FAIL %s_timeout got no frame_done want two pulses", tag); end
  endtask

  task automatic test_reset();
    reset = 1'b1; freeze = 1'b0; cfg_split = 1'b0; cfg_dec = 2'b01; cfg_lzb = 1'b1;
    input_value = 32'h00BC614E;
    repeat (3) @(negedge clk);
    checks++; if (display !== 32'h0) begin errors++; $display("FAIL rst_display got %h want 0", display); end
    checks++; if (digit_enable !== 8'h0) begin errors++; $display("FAIL rst_en got %h want 0", digit_enable); end
    checks++; if (field_ovf !== 2'b00) begin errors++; $display("FAIL rst_ovf got %b want 00", field_ovf); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", frame_done); end
  endtask

  task automatic test_single_dec_latency();
    int n;
    bit ok;
    reset = 1'b0;
    wait_done(100, n, ok);
    checks++; if (!ok || n != 34) begin errors++; $display("FAIL dec_latency got %0d want 34", n); end
    checks++; if (display !== 32'h12345678) begin errors++; $display("FAIL dec_display got %h want 12345678", display); end
    checks++; if (digit_enable !== 8'hFF) begin errors++; $display("FAIL dec_en got %h want ff", digit_enable); end
    checks++; if (field_ovf !== 2'b00) begin errors++; $display("FAIL dec_ovf got %b want 00", field_ovf); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", frame_done); end
    wait_done(100, n, ok);
    checks++; if (!ok || n != 33) begin errors++; $display("FAIL dec_period got %0d want 34", n + 1); end
  endtask

  task automatic test_single_hex();
    int n;
    bit ok;
    cfg_dec = 2'b00; input_value = 32'h00001A2F;
    settle("hex");
    checks++; if (display !== 32'h00001A2F) begin errors++; $display("FAIL hex_display got %h want 00001a2f", display); end
    checks++; if (digit_enable !== 8'h0F) begin errors++; $display("FAIL hex_en got %h want 0f", digit_enable); end
    wait_done(10, n, ok);
    checks++; if (!ok || n != 2) begin errors++; $display("FAIL hex_period got %0d want 2", n); end
  endtask

  task automatic test_single_dec_ovf();
    cfg_dec = 2'b01; input_value = 32'hFFFFFFFF;
    settle("ovf");
    checks++; if (display !== 32'h99999999) begin errors++; $display("FAIL ovf_display got %h want 99999999", display); end
    checks++; if (field_ovf !== 2'b01) begin errors++; $display("FAIL ovf_flag got %b want 01", field_ovf); end
    checks++; if (digit_enable !== 8'hFF) begin errors++; $display("FAIL ovf_en got %h want ff", digit_enable); end
    input_value = 32'h00000000;
    settle("zero");
    checks++; if (display !== 32'h0) begin errors++; $display("FAIL zero_display got %h want 0", display); end
    checks++; if (digit_enable !== 8'h01) begin errors++; $display("FAIL zero_en got %h want 01", digit_enable); end
    checks++; if (field_ovf !== 2'b00) begin errors++; $display("FAIL zero_ovf got %b want 00", field_ovf); end
  endtask

  task automatic test_split_mixed();
    cfg_split = 1'b1; cfg_dec = 2'b01; input_value = 32'hBEEF0309;
    settle("split");
    checks++; if (display !== 32'hBEEF0777) begin errors++; $display("FAIL split_display got %h want beef0777", display); end
    checks++; if (digit_enable !== 8'hF7) begin errors++; $display("FAIL split_en got %h want f7", digit_enable); end
    checks++; if (field_ovf !== 2'b00) begin errors++; $display("FAIL split_ovf got %b want 00", field_ovf); end
    cfg_lzb = 1'b0;
    settle("nolzb");
    checks++; if (digit_enable !== 8'hFF) begin errors++; $display("FAIL nolzb_en got %h want ff", digit_enable); end
    checks++; if (display !== 32'hBEEF0777) begin errors++; $display("FAIL nolzb_display got %h want beef0777", display); end
  endtask

  task automatic test_split_ovf_toggle();
    int n;
    bit ok;
    cfg_lzb = 1'b1; cfg_dec = 2'b11; input_value = 32'h0000FFFF;
    settle("split_ovf");
    checks++; if (display !== 32'h00009999) begin errors++; $display("FAIL sovf_display got %h want 00009999", display); end
    checks++; if (field_ovf !== 2'b01) begin errors++; $display("FAIL sovf_flag got %b want 01", field_ovf); end
    checks++; if (digit_enable !== 8'h1F) begin errors++; $display("FAIL sovf_en got %h want 1f", digit_enable); end
    wait_done(100, n, ok);
    checks++; if (!ok || n != 36) begin errors++; $display("FAIL split_period got %0d want 36", n); end
    @(negedge clk);
    cfg_split = 1'b0;
    wait_done(100, n, ok);
    checks++; if (!ok || n != 35) begin errors++; $display("FAIL toggle_cur_frame got %0d want 35", n); end
    checks++; if (display !== 32'h00009999) begin errors++; $display("FAIL toggle_cur_display got %h want 00009999", display); end
    wait_done(100, n, ok);
    checks++; if (!ok || n != 34) begin errors++; $display("FAIL toggle_next_frame got %0d want 34", n); end
    checks++; if (display !== 32'h00065535) begin errors++; $display("FAIL toggle_display got %h want 00065535", display); end
    checks++; if (digit_enable !== 8'h1F) begin errors++; $display("FAIL toggle_en got %h want 1f", digit_enable); end
    checks++; if (field_ovf !== 2'b00) begin errors++; $display("FAIL toggle_ovf got %b want 00", field_ovf); end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    bit ok;
    cfg_dec = 2'b01; input_value = 32'h00BC614E;
    settle("pre_rst");
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (display !== 32'h0 || digit_enable !== 8'h0 || field_ovf !== 2'b00 || frame_done !== 1'b0)
      begin errors++; $display("FAIL midrst_outputs got %h/%h/%b/%b want all 0", display, digit_enable, field_ovf, frame_done); end
    @(negedge clk);
    reset = 1'b0;
    wait_done(100, n, ok);
    checks++; if (!ok || n != 34) begin errors++; $display("FAIL midrst_latency got %0d want 34", n); end
    checks++; if (display !== 32'h12345678) begin errors++; $display("FAIL midrst_display got %h want 12345678", display); end
  endtask

  task automatic test_freeze();
    freeze = 1'b1; input_value = 32'h0000007B;
    settle("freeze");
    checks++; if (display !== 32'h12345678) begin errors++; $display("FAIL frz_display got %h want 12345678", display); end
    checks++; if (digit_enable !== 8'hFF) begin errors++; $display("FAIL frz_en got %h want ff", digit_enable); end
    freeze = 1'b0;
    settle("unfreeze");
    checks++; if (display !== 32'h00000123) begin errors++; $display("FAIL unfrz_display got %h want 00000123", display); end
    checks++; if (digit_enable !== 8'h07) begin errors++; $display("FAIL unfrz_en got %h want 07", digit_enable); end
  endtask

  initial begin
    test_reset();
    test_single_dec_latency();
    test_single_hex();
    test_single_dec_ovf();
    test_split_mixed();
    test_split_ovf_toggle();
    test_reset_mid_shift();
    test_freeze();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
